// File: rtl/edge_event_pkg.sv
// Shared constants and helpers for the edge event counter slice.
package edge_event_pkg;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  // All-ones value of a counter of the given width.
  function automatic longint unsigned cnt_max(int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous event line and flags the selected edge once the
// chain has settled after reset.
module sync_edge_detect
  import edge_event_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = EDGE_RISE
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_evt_in,
  output logic o_edge
);

  localparam int unsigned ArmW = $clog2(SYNC_STAGES + 2);
  localparam logic [ArmW-1:0] ArmDone = ArmW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [ArmW-1:0]        r_arm;

  logic w_s;
  logic w_rise;
  logic w_fall;
  logic w_sel;
  logic w_armed;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_s & ~r_hist;
  assign w_fall  = ~w_s & r_hist;
  assign w_armed = (r_arm == ArmDone);

  always_comb begin
    w_sel = 1'b0;
    case (EDGE_MODE)
      EDGE_RISE: w_sel = w_rise;
      EDGE_FALL: w_sel = w_fall;
      default:   w_sel = w_rise | w_fall;
    endcase
  end

  assign o_edge = w_sel & w_armed;

  // History keeps tracking while disarmed so the first armed cycle sees a settled pair.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_arm  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_evt_in};
      r_hist <= w_s;
      if (!w_armed) begin
        r_arm <= r_arm + 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_event_counter.sv
// Single-clock up/down event counter with load, clear, terminal count and a
// sticky wrap flag, fed by a synchronised edge detector.
module edge_event_counter
  import edge_event_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned EDGE_MODE   = EDGE_RISE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_evt_in,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_ovf,
  output logic             o_evt_pulse
);

  localparam logic [WIDTH-1:0] CntMax = WIDTH'(cnt_max(WIDTH));

  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;
  logic             r_evt_pulse;

  logic             w_edge;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_MODE  (EDGE_MODE)
  ) u_sync_edge_detect (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_evt_in(i_evt_in),
    .o_edge  (w_edge)
  );

  // Clear beats load beats count; an event colliding with either is dropped.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (i_clr) begin
      w_cnt_nxt = '0;
      w_ovf_nxt = 1'b0;
    end else if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (i_en && w_edge) begin
      if (i_up_dn) begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CntMax) begin
          w_ovf_nxt = 1'b1;
        end
      end else begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == '0) begin
          w_ovf_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_evt_pulse <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_evt_pulse <= w_edge;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_ovf       = r_ovf;
  assign o_evt_pulse = r_evt_pulse;
  assign o_tc        = i_up_dn ? (r_cnt == CntMax) : (r_cnt == '0);

endmodule

// File: tb/tb_edge_event_counter.sv
// Directed bench for edge_event_counter: a rising-edge instance and a
// both-edge instance share all inputs.
module tb_edge_event_counter;

  logic       clk;
  logic       rstn;
  logic       evt_in;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic       clr;

  logic [3:0] cnt_r;
  logic       tc_r;
  logic       ovf_r;
  logic       pulse_r;
  logic [3:0] cnt_b;
  logic       tc_b;
  logic       ovf_b;
  logic       pulse_b;

  int n_cmp;
  int n_err;

  edge_event_counter #(
    .WIDTH      (4),
    .EDGE_MODE  (0),
    .SYNC_STAGES(2)
  ) u_dut_rise (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_evt_in   (evt_in),
    .i_en       (en),
    .i_up_dn    (up_dn),
    .i_load     (load),
    .i_load_val (load_val),
    .i_clr      (clr),
    .o_cnt      (cnt_r),
    .o_tc       (tc_r),
    .o_ovf      (ovf_r),
    .o_evt_pulse(pulse_r)
  );

  edge_event_counter #(
    .WIDTH      (4),
    .EDGE_MODE  (2),
    .SYNC_STAGES(2)
  ) u_dut_both (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_evt_in   (evt_in),
    .i_en       (en),
    .i_up_dn    (up_dn),
    .i_load     (load),
    .i_load_val (load_val),
    .i_clr      (clr),
    .o_cnt      (cnt_b),
    .o_tc       (tc_b),
    .o_ovf      (ovf_b),
    .o_evt_pulse(pulse_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rising edge on evt_in; returns just after the edge that updates cnt.
  task automatic rise_evt();
    evt_in = 1'b0;
    step(4);
    evt_in = 1'b1;
    step(3);
  endtask

  initial begin
    logic seen;
    n_cmp    = 0;
    n_err    = 0;
    rstn     = 1'b0;
    evt_in   = 1'b1;
    en       = 1'b1;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 4'd0;
    clr      = 1'b0;

    // Reset with evt_in high, then release: no spurious rise.
    step(3);
    chk("rst_cnt", 32'(cnt_r), 32'd0);
    chk("rst_ovf", 32'(ovf_r), 32'd0);
    chk("rst_pulse", 32'(pulse_r), 32'd0);
    chk("rst_tc_up", 32'(tc_r), 32'd0);
    up_dn = 1'b0;
    #1;
    chk("rst_tc_dn", 32'(tc_r), 32'd1);
    up_dn = 1'b1;
    rstn  = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      seen = seen | pulse_r;
    end
    chk("arm_no_pulse", 32'(seen), 32'd0);
    chk("arm_cnt", 32'(cnt_r), 32'd0);
    rise_evt();
    chk("first_rise_pulse", 32'(pulse_r), 32'd1);
    chk("first_rise_cnt", 32'(cnt_r), 32'd1);
    step(1);
    chk("pulse_one_cycle", 32'(pulse_r), 32'd0);

    // Up count through wrap.
    load_val = 4'd14;
    load     = 1'b1;
    step(1);
    load = 1'b0;
    chk("load14_cnt", 32'(cnt_r), 32'd14);
    chk("load14_tc", 32'(tc_r), 32'd0);
    rise_evt();
    chk("up15_cnt", 32'(cnt_r), 32'd15);
    chk("up15_tc", 32'(tc_r), 32'd1);
    chk("up15_ovf", 32'(ovf_r), 32'd0);
    rise_evt();
    chk("wrap0_cnt", 32'(cnt_r), 32'd0);
    chk("wrap0_ovf", 32'(ovf_r), 32'd1);
    chk("wrap0_tc", 32'(tc_r), 32'd0);
    rise_evt();
    chk("up1_cnt", 32'(cnt_r), 32'd1);
    chk("up1_ovf_sticky", 32'(ovf_r), 32'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_cnt", 32'(cnt_r), 32'd0);
    chk("clr_ovf", 32'(ovf_r), 32'd0);

    // Down count through wrap.
    load_val = 4'd1;
    load     = 1'b1;
    step(1);
    load  = 1'b0;
    up_dn = 1'b0;
    #1;
    chk("dn1_tc", 32'(tc_r), 32'd0);
    rise_evt();
    chk("dn0_cnt", 32'(cnt_r), 32'd0);
    chk("dn0_tc", 32'(tc_r), 32'd1);
    rise_evt();
    chk("dn15_cnt", 32'(cnt_r), 32'd15);
    chk("dn15_ovf", 32'(ovf_r), 32'd1);
    chk("dn15_tc", 32'(tc_r), 32'd0);
    up_dn = 1'b1;

    // Event coincident with load.
    evt_in = 1'b0;
    step(4);
    evt_in = 1'b1;
    step(2);
    load_val = 4'd7;
    load     = 1'b1;
    step(1);
    load = 1'b0;
    chk("evt_load_cnt", 32'(cnt_r), 32'd7);
    chk("evt_load_pulse", 32'(pulse_r), 32'd1);
    chk("evt_load_ovf", 32'(ovf_r), 32'd1);

    // Event coincident with clear.
    evt_in = 1'b0;
    step(4);
    evt_in = 1'b1;
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("evt_clr_cnt", 32'(cnt_r), 32'd0);
    chk("evt_clr_ovf", 32'(ovf_r), 32'd0);

    // Clear and load together.
    load_val = 4'd7;
    load     = 1'b1;
    clr      = 1'b1;
    step(1);
    load = 1'b0;
    clr  = 1'b0;
    chk("clr_load_cnt", 32'(cnt_r), 32'd0);

    // Enable gating: pulses still fire, only the enabled event counts.
    en = 1'b0;
    rise_evt();
    chk("en0_a_pulse", 32'(pulse_r), 32'd1);
    chk("en0_a_cnt", 32'(cnt_r), 32'd0);
    rise_evt();
    chk("en0_b_pulse", 32'(pulse_r), 32'd1);
    chk("en0_b_cnt", 32'(cnt_r), 32'd0);
    step(2);
    en = 1'b1;
    step(2);
    chk("reen_no_stale", 32'(cnt_r), 32'd0);
    rise_evt();
    chk("en1_pulse", 32'(pulse_r), 32'd1);
    chk("en1_cnt", 32'(cnt_r), 32'd1);

    // Both-edge instance: 0->1->0, each level held 4 clocks.
    evt_in = 1'b0;
    step(5);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("both_clr_cnt", 32'(cnt_b), 32'd0);
    evt_in = 1'b1;
    step(2);
    chk("both_rise_early", 32'(pulse_b), 32'd0);
    step(1);
    chk("both_rise_pulse", 32'(pulse_b), 32'd1);
    chk("both_rise_cnt", 32'(cnt_b), 32'd1);
    step(1);
    chk("both_rise_end", 32'(pulse_b), 32'd0);
    evt_in = 1'b0;
    step(2);
    chk("both_fall_early", 32'(pulse_b), 32'd0);
    step(1);
    chk("both_fall_pulse", 32'(pulse_b), 32'd1);
    chk("both_fall_cnt", 32'(cnt_b), 32'd2);
    step(1);
    chk("both_fall_end", 32'(pulse_b), 32'd0);
    step(4);
    chk("both_final_cnt", 32'(cnt_b), 32'd2);

    // Reset mid-count at cnt=9 with ovf set.
    load_val = 4'd15;
    load     = 1'b1;
    step(1);
    load = 1'b0;
    rise_evt();
    chk("pre_rst_ovf", 32'(ovf_r), 32'd1);
    load_val = 4'd9;
    load     = 1'b1;
    step(1);
    load = 1'b0;
    chk("pre_rst_cnt", 32'(cnt_r), 32'd9);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    chk("mid_rst_cnt", 32'(cnt_r), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_r), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      seen = seen | pulse_r;
    end
    chk("rearm_no_pulse", 32'(seen), 32'd0);
    chk("rearm_cnt", 32'(cnt_r), 32'd0);
    rise_evt();
    chk("post_rst_cnt", 32'(cnt_r), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
